debouncer_multi: RTL

- Per-channel debouncer and button conditioner, the parametrised successor to the single-counter debouncer.
- Each of N_CH inputs has its own stable-time counter, so channels settle independently.
- Adds per-channel polarity, press/release edge pulses and long-press detection.
- Sits between raw board buttons/switches and the function-generator control FSM. A shared tick prescaler keeps per-channel counters narrow.

---
 rtl/debouncer_multi.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel button/switch conditioner.
// Each channel has a two-flop synchroniser, optional active-low inversion,
// a stable-time debounce counter clocked by a shared tick prescaler,
// press/release edge pulses and long-press detection.
// Optional feature macro: DEBOUNCER_MULTI_AUTOREPEAT_EN. When it is defined,
// long_pulse re-fires every REPEAT_TICKS ticks while the channel stays held.
module debouncer_multi #(
    parameter int              N_CH           = 4,
    parameter int              TICK_DIV       = 100_000,
    parameter int              DEBOUNCE_TICKS = 20,
    parameter int              LONG_TICKS     = 1000,
    parameter logic [N_CH-1:0] INVERT_MASK    = '0,
    parameter int              REPEAT_TICKS   = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] data_in,
    output logic [N_CH-1:0] data_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic            tick
);

    localparam int                DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE  = DIV_W'(TICK_DIV - 2);
    localparam int                CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    typedef enum logic {RELEASED = 1'b0, ASSERTED = 1'b1} state_t;

    // Reject configurations the counters cannot represent.
    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || LONG_TICKS < 0 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("debouncer_multi: illegal parameter value");
    end

    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [N_CH-1:0]  r_sync1;
    logic [N_CH-1:0]  r_sync2;
    logic [N_CH-1:0]  w_lin;

    // Shared prescaler; tick is registered so it is high while r_div == TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            r_tick <= (r_div == DIV_PRE);
        end
    end

    // Two-flop synchroniser; resets to the idle (released) raw level of each channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= INVERT_MASK;
            r_sync2 <= INVERT_MASK;
        end else begin
            r_sync1 <= data_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lin = r_sync2 ^ INVERT_MASK;
    assign tick  = r_tick;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_rise;
        logic             r_fall;
        logic             w_level;
        logic             w_stay;

        assign w_level = (r_state == ASSERTED);
        // Held means asserted now and not being released on this cycle.
        assign w_stay  = (r_state == ASSERTED) && (w_state_nxt == ASSERTED);

        // State, stable-time counter and edge pulses coincident with the new level.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= RELEASED;
                r_cnt   <= '0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_rise  <= (r_state == RELEASED) && (w_state_nxt == ASSERTED);
                r_fall  <= (r_state == ASSERTED) && (w_state_nxt == RELEASED);
            end
        end

        // Any cycle where the input agrees with the output restarts the count.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            if (w_lin[g] == w_level) begin
                w_cnt_nxt = '0;
            end else if (r_tick) begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = w_lin[g] ? ASSERTED : RELEASED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end

        assign data_out[g]   = w_level;
        assign rise_pulse[g] = r_rise;
        assign fall_pulse[g] = r_fall;

        if (LONG_TICKS > 0) begin : g_long
            localparam int                HOLD_W    = $clog2(LONG_TICKS + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
            localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

            logic [HOLD_W-1:0] r_hold;
            logic              r_long;
            logic              w_first_fire;
            logic              w_rep_fire;

            // A release on the same tick suppresses the long pulse via w_stay.
            assign w_first_fire = w_stay && r_tick && (r_hold == HOLD_LAST);

`ifdef DEBOUNCER_MULTI_AUTOREPEAT_EN
            localparam int               REP_W    = $clog2(REPEAT_TICKS + 1);
            localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

            logic [REP_W-1:0] r_rep;

            assign w_rep_fire = w_stay && r_tick && (r_hold == HOLD_MAX) && (r_rep == REP_LAST);

            // Repeat counter runs only once the hold counter has saturated.
            always_ff @(posedge clk) begin
                if (rst || !w_stay) begin
                    r_rep <= '0;
                end else if (r_tick && (r_hold == HOLD_MAX)) begin
                    r_rep <= (r_rep == REP_LAST) ? '0 : r_rep + REP_W'(1);
                end
            end
`else
            assign w_rep_fire = 1'b0;
`endif

            // Saturating hold counter and the registered long-press pulse.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hold <= '0;
                    r_long <= 1'b0;
                end else begin
                    r_long <= w_first_fire || w_rep_fire;
                    if (!w_stay) begin
                        r_hold <= '0;
                    end else if (r_tick && (r_hold != HOLD_MAX)) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
            end

            assign long_pulse[g] = r_long;
        end else begin : g_no_long
            assign long_pulse[g] = 1'b0;
        end
    end

endmodule
